// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command bridge that halts the CPU and issues 16-bit bus reads/writes,
// answering each command with ACK/NAK or read data on the transmit side.
module uart_bus_master #(
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 50000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [15:0] o_bus_addr,
   output logic [15:0] o_bus_wdata,
   output logic        o_bus_we,
   output logic        o_bus_en,
   input  logic [15:0] i_bus_rdata,
   output logic        o_cpu_hold,
   input  logic        i_cpu_idle,
   output logic        o_rx_drop
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;
   typedef enum logic [2:0] {IDLE, ARGS, WAIT_IDLE, BUS_WR, BUS_RD, RESP} state_t;
   state_t        state_q;
   logic          hold_q, is_wr_q, two_q, tx_valid_q, bus_en_q, bus_we_q, drop_q;
   logic [1:0]    argc_q, cnt_q;
   logic [23:0]   sh_q;
   logic [TW-1:0] tmo_q;
   logic [15:0]   addr_q, wdata_q;
   logic [7:0]    tx_data_q, lo_q;
   logic          last_arg;
   assign last_arg = argc_q == (is_wr_q ? 2'd3 : 2'd1);
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         hold_q     <= 1'b0;
         is_wr_q    <= 1'b0;
         two_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         bus_en_q   <= 1'b0;
         bus_we_q   <= 1'b0;
         drop_q     <= 1'b0;
         argc_q     <= '0;
         cnt_q      <= '0;
         sh_q       <= '0;
         tmo_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         tx_data_q  <= '0;
         lo_q       <= '0;
      end else begin
         drop_q <= i_rx_valid && state_q != IDLE && state_q != ARGS;
         case (state_q)
            IDLE: if (i_rx_valid) begin
               argc_q  <= '0;
               tmo_q   <= '0;
               is_wr_q <= i_rx_data == 8'h57;
               two_q   <= 1'b0;
               if (i_rx_data == 8'h57 || i_rx_data == 8'h52) state_q <= ARGS;
               else if (i_rx_data == 8'h48) begin
                  hold_q  <= 1'b1;
                  state_q <= WAIT_IDLE;
               end else begin
                  if (i_rx_data == 8'h47) hold_q <= 1'b0;
                  tx_data_q  <= i_rx_data == 8'h47 ? ACK : NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            ARGS: if (i_rx_valid) begin
               sh_q   <= {sh_q[15:0], i_rx_data};
               argc_q <= argc_q + 2'd1;
               tmo_q  <= '0;
               if (last_arg) begin
                  addr_q  <= is_wr_q ? sh_q[23:8] : {sh_q[7:0], i_rx_data};
                  wdata_q <= {sh_q[7:0], i_rx_data};
                  cnt_q   <= '0;
                  if (hold_q && i_cpu_idle) begin
                     bus_en_q <= 1'b1;
                     bus_we_q <= is_wr_q;
                     state_q  <= is_wr_q ? BUS_WR : BUS_RD;
                  end else begin
                     tx_data_q  <= NAK;
                     tx_valid_q <= 1'b1;
                     state_q    <= RESP;
                  end
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) state_q <= IDLE;
            else tmo_q <= tmo_q + 1'b1;
            WAIT_IDLE: if (i_cpu_idle) begin
               tx_data_q  <= ACK;
               tx_valid_q <= 1'b1;
               state_q    <= RESP;
            end
            BUS_WR: begin
               bus_en_q   <= 1'b0;
               bus_we_q   <= 1'b0;
               tx_data_q  <= ACK;
               tx_valid_q <= 1'b1;
               state_q    <= RESP;
            end
            BUS_RD: if (cnt_q == 2'(RD_LAT)) begin
               bus_en_q   <= 1'b0;
               tx_data_q  <= i_bus_rdata[15:8];
               lo_q       <= i_bus_rdata[7:0];
               two_q      <= 1'b1;
               tx_valid_q <= 1'b1;
               state_q    <= RESP;
            end else cnt_q <= cnt_q + 2'd1;
            RESP: if (tx_valid_q && i_tx_ready) begin
               if (two_q) begin
                  tx_data_q <= lo_q;
                  two_q     <= 1'b0;
               end else begin
                  tx_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign o_tx_data   = tx_data_q;
   assign o_tx_valid  = tx_valid_q;
   assign o_bus_addr  = addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_en    = bus_en_q;
   assign o_cpu_hold  = hold_q;
   assign o_rx_drop   = drop_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed protocol scenarios plus random W/R/unknown traffic checked
// against a shadow memory model and expected response byte sequences.
module tb_uart_bus_master;
   localparam int TMO = 300;
   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  rx_data = '0, tx_data;
   logic        rx_valid = 1'b0, tx_valid, tx_ready = 1'b0;
   logic [15:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_we, bus_en, cpu_hold, cpu_idle = 1'b0, rx_drop;
   int          checks = 0, errors = 0;
   int          en_cnt = 0, we_cnt = 0;
   logic [15:0] last_wa = '0, last_wd = '0;
   logic [15:0] mem [1024];
   logic [15:0] exp_mem [1024];
   int          waddrs [$];
   always #5 clk = ~clk;
   uart_bus_master #(.RD_LAT(1), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_we(bus_we), .o_bus_en(bus_en),
      .i_bus_rdata(bus_rdata), .o_cpu_hold(cpu_hold), .i_cpu_idle(cpu_idle), .o_rx_drop(rx_drop)
   );
   // bus slave: RAM with one cycle of read latency
   always @(posedge clk) begin
      if (bus_en) begin
         en_cnt <= en_cnt + 1;
         if (bus_we) begin
            we_cnt <= we_cnt + 1;
            last_wa <= bus_addr;
            last_wd <= bus_wdata;
            mem[bus_addr[9:0]] <= bus_wdata;
         end
      end
      bus_rdata <= mem[bus_addr[9:0]];
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask
   task automatic wait_valid(input string tag);
      for (int i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
   endtask
   task automatic expect_tx(input string tag, input logic [7:0] exp);
      wait_valid(tag);
      chk(tag, 64'(tx_data), 64'(exp));
      if (tx_valid) begin
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
   endtask
   task automatic do_write(input int a, input logic [15:0] d);
      send(8'h57); send(8'(a >> 8)); send(8'(a)); send(d[15:8]); send(d[7:0]);
      expect_tx("wr_ack", 8'h06);
      exp_mem[a] = d;
      waddrs.push_back(a);
   endtask
   task automatic do_read(input int a);
      send(8'h52); send(8'(a >> 8)); send(8'(a));
      expect_tx("rd_hi", exp_mem[a][15:8]);
      expect_tx("rd_lo", exp_mem[a][7:0]);
   endtask
   initial begin
      int e0, w0, nw, nr, a;
      logic [7:0] b;
      logic ok;
      repeat (3) @(negedge clk);
      chk("reset_outs", {tx_valid, bus_en, bus_we, cpu_hold, rx_drop, tx_data, bus_addr, bus_wdata}, 64'd0);
      rst = 1'b0;
      send(8'h48);
      repeat (5) @(negedge clk);
      chk("hold_set", 64'(cpu_hold), 64'd1);
      chk("no_ack_before_idle", 64'(tx_valid), 64'd0);
      cpu_idle = 1'b1;
      expect_tx("h_ack", 8'h06);
      e0 = en_cnt; w0 = we_cnt;
      do_write(16'h0123, 16'hBEEF);
      chk("wr_pulse", {32'(en_cnt - e0), 32'(we_cnt - w0)}, {32'd1, 32'd1});
      chk("wr_addr_data", {last_wa, last_wd}, {16'h0123, 16'hBEEF});
      do_write(16'h0123, 16'hCAFE);
      e0 = en_cnt;
      send(8'h52); send(8'h01); send(8'h23);
      wait_valid("rd_hold");
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!tx_valid || tx_data !== 8'hCA) ok = 1'b0;
      end
      chk("tx_stable", 64'(ok), 64'd1);
      chk("rd_en_cycles", 64'(en_cnt - e0), 64'd2);
      expect_tx("cafe_hi", 8'hCA);
      expect_tx("cafe_lo", 8'hFE);
      send(8'h47);
      expect_tx("g_ack", 8'h06);
      chk("hold_clr", 64'(cpu_hold), 64'd0);
      e0 = en_cnt;
      send(8'h57); send(8'h00); send(8'h10); send(8'h00); send(8'h01);
      expect_tx("nohold_nak", 8'h15);
      chk("nohold_no_bus", 64'(en_cnt - e0), 64'd0);
      send(8'h99);
      expect_tx("unknown_nak", 8'h15);
      send(8'h57); send(8'h00);
      ok = 1'b1;
      for (int i = 0; i < TMO + 10; i++) begin
         @(negedge clk);
         if (tx_valid) ok = 1'b0;
      end
      chk("timeout_silent", 64'(ok), 64'd1);
      send(8'h47);
      expect_tx("after_timeout_ack", 8'h06);
      chk("after_timeout_hold", 64'(cpu_hold), 64'd0);
      send(8'h48);
      expect_tx("h2_ack", 8'h06);
      send(8'h52); send(8'h01); send(8'h23);
      wait_valid("drop_resp");
      send(8'h47);
      chk("rx_drop", 64'(rx_drop), 64'd1);
      expect_tx("drop_hi", 8'hCA);
      expect_tx("drop_lo", 8'hFE);
      chk("drop_keeps_hold", 64'(cpu_hold), 64'd1);
      e0 = en_cnt; w0 = we_cnt; nw = 0; nr = 0;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 2))
            0: begin do_write($urandom_range(0, 1023), 16'($urandom)); nw++; end
            1: if (waddrs.size() == 0) begin do_write($urandom_range(0, 1023), 16'($urandom)); nw++; end
               else begin
                  a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                  do_read(a); nr++;
               end
            default: begin
               b = 8'($urandom);
               if (b == 8'h48 || b == 8'h47 || b == 8'h57 || b == 8'h52) b = 8'h00;
               send(b);
               expect_tx("rand_nak", 8'h15);
            end
         endcase
      end
      chk("rand_bus_counts", {32'(en_cnt - e0), 32'(we_cnt - w0)}, {32'(nw + 2 * nr), 32'(nw)});
      send(8'h52); send(8'h00); send(8'h10);
      for (int i = 0; i < 20 && !bus_en; i++) @(negedge clk);
      chk("rd_bus_en", 64'(bus_en), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_reset_outs", {tx_valid, bus_en, bus_we, cpu_hold, rx_drop}, 64'd0);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
